// File: rtl/div_pkg.sv
// Shared types and defaults for the divider front-end controller.
package div_pkg;

    localparam int W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Bundle of the signals exchanged between the sequencer and the restoring divider.
interface div_sequencer_if
    import div_pkg::*;
#(
    parameter int W = W_DEF
);

    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic         div_load;
    logic         div_init;
    logic         div_done;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;

    modport master (
        output div_a, div_b, div_load, div_init,
        input  div_done, div_q, div_r
    );

    modport slave (
        input  div_a, div_b, div_load, div_init,
        output div_done, div_q, div_r
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-sample counter; emits a one-cycle pulse on a debounced press.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int            CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= raw;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            // Any sample agreeing with the current level restarts the stability count.
            if (r_s2 != r_level) begin
                if (r_cnt == CMAX) begin
                    r_level <= r_s2;
                    r_rise  <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/div_sequencer.sv
// Front-end controller: debounced "go" starts the divider, waits for done, latches the result.
module div_sequencer
    import div_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_btn_go,
    input  logic [W-1:0]          i_sw_a,
    input  logic [W-1:0]          i_sw_b,
    div_sequencer_if.master       bus,
    output logic [W-1:0]          o_q_out,
    output logic [W-1:0]          o_r_out,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_dz,
    output logic                  o_err
);

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [W-1:0]  r_q;
    logic [W-1:0]  r_r;
    logic          r_valid;
    logic          r_busy;
    logic          r_dz;
    logic          r_err;
    logic          r_load;
    logic          r_init;
    logic          r_done_q;
    logic [TW-1:0] r_tmo;

    logic w_btn_level;
    logic w_btn_rise;
    logic w_go;
    logic w_done_rise;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (i_btn_go),
        .level (w_btn_level),
        .rise  (w_btn_rise)
    );

    assign w_go        = w_btn_rise & w_btn_level;
    assign w_done_rise = bus.div_done & ~r_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_q      <= '0;
            r_r      <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_dz     <= 1'b0;
            r_err    <= 1'b0;
            r_load   <= 1'b0;
            r_init   <= 1'b0;
            r_done_q <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_done_q <= bus.div_done;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_op_a  <= i_sw_a;
                        r_op_b  <= i_sw_b;
                        r_valid <= 1'b0;
                        r_dz    <= 1'b0;
                        r_err   <= 1'b0;
                        // Divide-by-zero is answered here; the divider is never started.
                        if (i_sw_b == '0) begin
                            r_q     <= '1;
                            r_r     <= i_sw_a;
                            r_dz    <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= LOAD;
                            r_load  <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_load  <= 1'b0;
                    r_init  <= 1'b1;
                    r_tmo   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_done_rise) begin
                        r_init  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= CAPTURE;
                    end else if (r_tmo == TMAX) begin
                        r_err   <= 1'b1;
                        r_init  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                CAPTURE: begin
                    r_q     <= bus.div_q;
                    r_r     <= bus.div_r;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.div_a    = r_op_a;
    assign bus.div_b    = r_op_b;
    assign bus.div_load = r_load;
    assign bus.div_init = r_init;

    assign o_q_out = r_q;
    assign o_r_out = r_r;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_dz    = r_dz;
    assign o_err   = r_err;

endmodule
